// File: rtl/d_imm_extend_pipe.sv
// Two-stage immediate extension pipeline: stage 1 decodes the opcode into an
// extension mode, stage 2 produces the extended immediate and branch target.
module d_imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IMM_W-1:0]  i_data_imm,
  input  logic [5:0]        i_data_opcode,
  input  logic [5:0]        i_data_funct,
  input  logic [DATA_W-1:0] i_data_pc,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_imm,
  output logic [2:0]        o_data_mode,
  output logic [DATA_W-1:0] o_data_btarget
);

  // Handshake: a beat moves on any cycle where valid && ready are both high;
  // the producer holds its fields stable while valid is high and ready is low.

  if (!((DATA_W == 32) || (DATA_W == 64)) || (DATA_W < 2 * IMM_W)) begin : g_bad_params
    $error("d_imm_extend_pipe: DATA_W must be 32 or 64 and at least 2*IMM_W");
  end

  localparam logic [2:0] MODE_ZERO   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_UPPER  = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_NONE   = 3'd4;

  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        s1_mode_q, s1_mode_d;
  logic [IMM_W-1:0]  s1_imm_q, s1_imm_d;
  logic [DATA_W-1:0] s1_pc_q, s1_pc_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic [2:0]        out_mode_q, out_mode_d;
  logic [DATA_W-1:0] out_btgt_q, out_btgt_d;

  logic              s2_free;
  logic              s1_adv;
  logic              in_ready;
  logic              accept;
  logic [2:0]        dec_mode;
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;

  // The funct field travels with the instruction but never affects the decode.
  logic unused_funct;
  assign unused_funct = ^i_data_funct;

  assign s2_free  = !out_valid_q || i_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !i_rst && (!s1_valid_q || s2_free);
  assign accept   = i_valid && in_ready && !i_flush;

  always_comb begin
    dec_mode = MODE_ZERO;
    case (i_data_opcode)
      6'b001111:                                         dec_mode = MODE_UPPER;
      6'b001000, 6'b001001, 6'b001010, 6'b100011, 6'b101011: dec_mode = MODE_SIGN;
      6'b000100, 6'b000101:                              dec_mode = MODE_BRANCH;
      6'b001100, 6'b001101, 6'b001110:                   dec_mode = MODE_ZERO;
      6'b000000:                                         dec_mode = MODE_NONE;
      default:                                           dec_mode = MODE_ZERO;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_imm_d   = s1_imm_q;
    s1_pc_d    = s1_pc_q;
    if (i_flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = dec_mode;
      s1_imm_d   = i_data_imm;
      s1_pc_d    = i_data_pc;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  assign sext = {{(DATA_W-IMM_W){s1_imm_q[IMM_W-1]}}, s1_imm_q};
  assign zext = {{(DATA_W-IMM_W){1'b0}}, s1_imm_q};

  always_comb begin
    out_valid_d = out_valid_q;
    out_imm_d   = out_imm_q;
    out_mode_d  = out_mode_q;
    out_btgt_d  = out_btgt_q;
    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_mode_d  = s1_mode_q;
      // Shifting the sign-extended value by IMM_W keeps the upper sign fill.
      case (s1_mode_q)
        MODE_SIGN:   out_imm_d = sext;
        MODE_UPPER:  out_imm_d = sext << IMM_W;
        MODE_BRANCH: out_imm_d = sext << 2;
        MODE_NONE:   out_imm_d = '0;
        default:     out_imm_d = zext;
      endcase
      out_btgt_d = s1_pc_q + DATA_W'(4) + (sext << 2);
    end else if (i_ready) begin
      out_valid_d = 1'b0;
    end
    if (i_flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= '0;
      s1_imm_q    <= '0;
      s1_pc_q     <= '0;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_mode_q  <= '0;
      out_btgt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_imm_q    <= s1_imm_d;
      s1_pc_q     <= s1_pc_d;
      out_valid_q <= out_valid_d;
      out_imm_q   <= out_imm_d;
      out_mode_q  <= out_mode_d;
      out_btgt_q  <= out_btgt_d;
    end
  end

  // Outputs read as zero for the whole reset window, including its first cycle.
  assign o_ready        = in_ready;
  assign o_valid        = out_valid_q && !i_rst;
  assign o_data_imm     = i_rst ? '0 : out_imm_q;
  assign o_data_mode    = i_rst ? '0 : out_mode_q;
  assign o_data_btarget = i_rst ? '0 : out_btgt_q;

endmodule

// File: tb/tb_d_imm_extend_pipe.sv
// Bench for d_imm_extend_pipe: directed scenarios followed by random traffic,
// checked against a transaction-level model of the extension rules.
module tb_d_imm_extend_pipe;

  localparam int DW = 32;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [IW-1:0] i_imm;
  logic [5:0]    i_op;
  logic [5:0]    i_funct;
  logic [DW-1:0] i_pc;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_imm;
  logic [2:0]    o_mode;
  logic [DW-1:0] o_btgt;

  logic          o_ready64;
  logic          o_valid64;
  logic [63:0]   o_imm64;
  logic [2:0]    o_mode64;
  logic [63:0]   o_btgt64;
  logic [63:0]   i_pc64;

  int n_cmp = 0;
  int n_bad = 0;
  int e     = 0;

  logic [66:0] exp_q[$];
  int          t_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) e++;

  assign i_pc64 = {32'h0, i_pc};

  d_imm_extend_pipe #(.DATA_W(DW), .IMM_W(IW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_imm(i_imm), .i_data_opcode(i_op), .i_data_funct(i_funct),
    .i_data_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_data_imm(o_imm), .o_data_mode(o_mode), .o_data_btarget(o_btgt)
  );

  d_imm_extend_pipe #(.DATA_W(64), .IMM_W(IW)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready64),
    .i_data_imm(i_imm), .i_data_opcode(i_op), .i_data_funct(i_funct),
    .i_data_pc(i_pc64), .i_flush(i_flush), .o_valid(o_valid64), .i_ready(1'b1),
    .o_data_imm(o_imm64), .o_data_mode(o_mode64), .o_data_btarget(o_btgt64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: {imm_ext, mode, btarget} from plain signed arithmetic.
  function automatic logic [66:0] model(input logic [5:0] op, input logic [IW-1:0] imm,
                                        input logic [DW-1:0] pc);
    longint s, ext, bt;
    logic [2:0] m;
    s = imm[IW-1] ? longint'(imm) - 65536 : longint'(imm);
    case (op)
      6'b001111:                                         m = 3'd2;
      6'b001000, 6'b001001, 6'b001010, 6'b100011, 6'b101011: m = 3'd1;
      6'b000100, 6'b000101:                              m = 3'd3;
      6'b000000:                                         m = 3'd4;
      default:                                           m = 3'd0;
    endcase
    case (m)
      3'd1:    ext = s;
      3'd2:    ext = s * 65536;
      3'd3:    ext = s * 4;
      3'd4:    ext = 0;
      default: ext = longint'(imm);
    endcase
    bt = longint'(pc) + 4 + s * 4;
    return {ext[31:0], m, bt[31:0]};
  endfunction

  always @(negedge clk) begin
    logic ready_exp, valid_exp;
    logic [66:0] hd;
    ready_exp = !rst && (exp_q.size() < 2 || i_ready);
    valid_exp = !rst && exp_q.size() > 0 && t_q[0] < e;
    chk("mon_o_ready", 64'(o_ready), 64'(ready_exp));
    chk("mon_o_valid", 64'(o_valid), 64'(valid_exp));
    if (valid_exp) begin
      hd = exp_q[0];
      chk("mon_imm", 64'(o_imm), 64'(hd[66:35]));
      chk("mon_mode", 64'(o_mode), 64'(hd[34:32]));
      chk("mon_btarget", 64'(o_btgt), 64'(hd[31:0]));
    end
    if (rst) begin
      chk("mon_rst_imm", 64'(o_imm), 64'h0);
      exp_q.delete();
      t_q.delete();
    end else begin
      if (valid_exp && i_ready) begin
        void'(exp_q.pop_front());
        void'(t_q.pop_front());
      end
      if (i_flush) begin
        exp_q.delete();
        t_q.delete();
      end else if (i_valid && ready_exp) begin
        exp_q.push_back(model(i_op, i_imm, i_pc));
        t_q.push_back(e + 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle, then wait until it is at the output.
  task automatic one(input logic [5:0] op, input logic [IW-1:0] imm, input logic [DW-1:0] pc);
    i_valid = 1'b1; i_op = op; i_imm = imm; i_pc = pc;
    step();
    i_valid = 1'b0;
    step();
  endtask

  logic [5:0] ops[14] = '{6'b001111, 6'b001000, 6'b001001, 6'b001010, 6'b100011,
                          6'b101011, 6'b000100, 6'b000101, 6'b001100, 6'b001101,
                          6'b001110, 6'b000000, 6'b111111, 6'b010001};

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_imm = '0; i_op = '0; i_funct = '0;
    i_pc = '0; i_flush = 1'b0; i_ready = 1'b1;
    repeat (3) step();
    chk("rst_o_valid", 64'(o_valid), 64'h0);
    chk("rst_o_ready", 64'(o_ready), 64'h0);
    chk("rst_o_btarget", 64'(o_btgt), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_o_ready", 64'(o_ready), 64'h1);

    one(6'b001000, 16'h8000, 32'h0000_1000);
    chk("sign_valid", 64'(o_valid), 64'h1);
    chk("sign_imm", 64'(o_imm), 64'hFFFF_8000);
    chk("sign_mode", 64'(o_mode), 64'h1);
    chk("sign_btarget", 64'(o_btgt), 64'hFFFE_1004);

    one(6'b001111, 16'h1234, 32'h0);
    chk("lui32_imm", 64'(o_imm), 64'h1234_0000);
    chk("lui32_mode", 64'(o_mode), 64'h2);
    one(6'b001111, 16'h8000, 32'h0);
    chk("lui32_neg_imm", 64'(o_imm), 64'h8000_0000);
    chk("lui64_valid", 64'(o_valid64), 64'h1);
    chk("lui64_imm", o_imm64, 64'hFFFF_FFFF_8000_0000);

    one(6'b000100, 16'hFFFF, 32'h0000_0100);
    chk("br_imm", 64'(o_imm), 64'hFFFF_FFFC);
    chk("br_btarget", 64'(o_btgt), 64'h0000_0100);
    chk("br_mode", 64'(o_mode), 64'h3);
    one(6'b000000, 16'h1234, 32'h0);
    chk("none_imm", 64'(o_imm), 64'h0);
    chk("none_mode", 64'(o_mode), 64'h4);
    one(6'b001101, 16'h8000, 32'h0);
    chk("zero_imm", 64'(o_imm), 64'h0000_8000);
    one(6'b111111, 16'hF00D, 32'h0);
    chk("dflt_imm", 64'(o_imm), 64'h0000_F00D);
    chk("dflt_mode", 64'(o_mode), 64'h0);
    step();

    // Backpressure: three back-to-back ZERO-mode inputs with downstream stalled.
    i_ready = 1'b0; i_valid = 1'b1; i_op = 6'b001100; i_pc = 32'h200;
    i_imm = 16'h00A1; #1;
    chk("bp_acc1", 64'(o_ready), 64'h1);
    step();
    i_imm = 16'h00A2; #1;
    chk("bp_acc2", 64'(o_ready), 64'h1);
    step();
    i_imm = 16'h00A3; #1;
    chk("bp_full", 64'(o_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 64'(o_valid), 64'h1);
      chk("bp_hold_imm", 64'(o_imm), 64'h0000_00A1);
    end
    i_ready = 1'b1; #1;
    chk("bp_release", 64'(o_ready), 64'h1);
    step();
    i_valid = 1'b0;
    chk("bp_drain1", 64'(o_imm), 64'h0000_00A2);
    step();
    chk("bp_drain2", 64'(o_imm), 64'h0000_00A3);
    step();
    chk("bp_empty", 64'(o_valid), 64'h0);

    // Flush with both stages full and a new input offered.
    i_ready = 1'b0; i_valid = 1'b1; i_op = 6'b001100;
    i_imm = 16'h00B1; step();
    i_imm = 16'h00B2; step();
    i_imm = 16'h00B3; i_flush = 1'b1; step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_o_valid", 64'(o_valid), 64'h0);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_quiet", 64'(o_valid), 64'h0);
    end

    // Reset in the middle of a stream.
    i_valid = 1'b1; i_op = 6'b001000; i_imm = 16'h00C1; step();
    i_imm = 16'h00C2; step();
    rst = 1'b1; #1;
    chk("mid_rst_valid", 64'(o_valid), 64'h0);
    chk("mid_rst_ready", 64'(o_ready), 64'h0);
    step();
    chk("mid_rst_imm", 64'(o_imm), 64'h0);
    chk("mid_rst_mode", 64'(o_mode), 64'h0);
    chk("mid_rst_btarget", 64'(o_btgt), 64'h0);
    rst = 1'b0; i_valid = 1'b0; #1;
    chk("mid_rst_ready_after", 64'(o_ready), 64'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mid_rst_no_output", 64'(o_valid), 64'h0);
    end

    // Random traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < 600; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_op    = ops[$urandom_range(0, 13)];
      i_imm   = IW'($urandom);
      i_pc    = $urandom;
      i_funct = 6'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      step();
    end
    i_valid = 1'b0; i_flush = 1'b0; rst = 1'b0; i_ready = 1'b1;
    repeat (5) step();
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
